// File: rtl/player_countdown.sv
// Per-player chess clock countdown: BCD MM:SS with sub-second ticks,
// Fischer increment on move completion and a registered time-out flag.
module player_countdown #(
  parameter int INIT_MIN      = 5,
  parameter int INIT_SEC      = 0,
  parameter int INC_SEC       = 0,
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       ENABLE,
  input  logic       LOAD,
  input  logic       MOVE_DONE,
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       END,
  output logic       LOW
);

  localparam int TW = (TICKS_PER_SEC > 1) ?
                      $clog2(TICKS_PER_SEC) : 1;

  localparam logic [TW-1:0] TICK_MAX =
    TW'(TICKS_PER_SEC - 1);

  localparam logic [3:0] I_MT = 4'(INIT_MIN / 10);
  localparam logic [3:0] I_MO = 4'(INIT_MIN % 10);
  localparam logic [3:0] I_ST = 4'(INIT_SEC / 10);
  localparam logic [3:0] I_SO = 4'(INIT_SEC % 10);
  localparam logic I_END =
    (INIT_MIN == 0) && (INIT_SEC == 0);

  localparam logic [4:0] INC_T = 5'(INC_SEC / 10);
  localparam logic [4:0] INC_O = 5'(INC_SEC % 10);

  logic [3:0]    mt_q, mo_q, st_q, so_q;
  logic [3:0]    mt_d, mo_d, st_d, so_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          end_q, end_d;

  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       b0, b1, b2, dec_zero;

  logic [4:0] so_sum, st_sum, mo_sum, mt_sum;
  logic [3:0] inc_mt, inc_mo, inc_st, inc_so;
  logic       c0, c1, c2, sat;

  // One-second BCD decrement with borrow chain.
  always_comb begin
    b0     = (so_q == 4'd0);
    dec_so = b0 ? 4'd9 : so_q - 4'd1;
    b1     = b0 && (st_q == 4'd0);
    dec_st = st_q;
    if (b0)
      dec_st = (st_q == 4'd0) ? 4'd5 : st_q - 4'd1;
    b2     = b1 && (mo_q == 4'd0);
    dec_mo = mo_q;
    if (b1)
      dec_mo = (mo_q == 4'd0) ? 4'd9 : mo_q - 4'd1;
    dec_mt = b2 ? mt_q - 4'd1 : mt_q;
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
               (dec_st == 4'd0) && (dec_so == 4'd0);
  end

  // Increment: seconds wrap at 60, minutes saturate at 99.
  always_comb begin
    so_sum = {1'b0, so_q} + INC_O;
    c0     = (so_sum > 5'd9);
    inc_so = c0 ? 4'(so_sum - 5'd10) : so_sum[3:0];
    st_sum = {1'b0, st_q} + INC_T + {4'd0, c0};
    c1     = (st_sum > 5'd5);
    inc_st = c1 ? 4'(st_sum - 5'd6) : st_sum[3:0];
    mo_sum = {1'b0, mo_q} + {4'd0, c1};
    c2     = (mo_sum > 5'd9);
    inc_mo = c2 ? 4'(mo_sum - 5'd10) : mo_sum[3:0];
    mt_sum = {1'b0, mt_q} + {4'd0, c2};
    sat    = (mt_sum > 5'd9);
    inc_mt = mt_sum[3:0];
  end

  always_comb begin
    mt_d   = mt_q;
    mo_d   = mo_q;
    st_d   = st_q;
    so_d   = so_q;
    tick_d = tick_q;
    end_d  = end_q;
    if (LOAD) begin
      mt_d   = I_MT;
      mo_d   = I_MO;
      st_d   = I_ST;
      so_d   = I_SO;
      tick_d = '0;
      end_d  = I_END;
    end else if (end_q) begin
      end_d = 1'b1;
    end else if (MOVE_DONE) begin
      if (sat) begin
        mt_d = 4'd9;
        mo_d = 4'd9;
        st_d = 4'd5;
        so_d = 4'd9;
      end else begin
        mt_d = inc_mt;
        mo_d = inc_mo;
        st_d = inc_st;
        so_d = inc_so;
      end
    end else if (ENABLE) begin
      if (tick_q != TICK_MAX) begin
        tick_d = tick_q + TW'(1);
      end else begin
        tick_d = '0;
        mt_d   = dec_mt;
        mo_d   = dec_mo;
        st_d   = dec_st;
        so_d   = dec_so;
        end_d  = dec_zero;
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      mt_q   <= I_MT;
      mo_q   <= I_MO;
      st_q   <= I_ST;
      so_q   <= I_SO;
      tick_q <= '0;
      end_q  <= I_END;
    end else begin
      mt_q   <= mt_d;
      mo_q   <= mo_d;
      st_q   <= st_d;
      so_q   <= so_d;
      tick_q <= tick_d;
      end_q  <= end_d;
    end
  end

  assign MIN_TENS = mt_q;
  assign MIN_ONES = mo_q;
  assign SEC_TENS = st_q;
  assign SEC_ONES = so_q;
  assign END      = end_q;
  assign LOW      = (mt_q == 4'd0) && (mo_q == 4'd0) &&
                    (st_q == 4'd0) && !end_q;

endmodule

// File: doc/player_countdown.md
Name: player_countdown

Overview:
Per-player countdown timer for the chess clock, directly downstream of the player-enable switch stage; one instance per player, driven by that player's enable strobe. Holds remaining time as BCD MM:SS plus a sub-second tick counter, decrements while enabled, and applies a Fischer increment on move completion. Flags time-out (END), which feeds back to the switch stage and the display and buzzer logic.

Parameters:
INIT_MIN, 5, preset minutes, 0..99
INIT_SEC, 0, preset seconds, 0..59
INC_SEC, 0, Fischer increment in seconds added per completed move, 0..59
TICKS_PER_SEC, 10, ENABLE strobes per displayed second, 2..256

Ports:
CLK  in  1  system clock
CLR  in  1  asynchronous active-high reset
ENABLE  in  1  count strobe from switch stage; each CLK cycle with ENABLE=1 is one sub-second tick
LOAD  in  1  synchronous reload of preset time
MOVE_DONE  in  1  one-cycle pulse: this player finished a move; apply increment
MIN_TENS  out  4  BCD minutes tens
MIN_ONES  out  4  BCD minutes ones
SEC_TENS  out  4  BCD seconds tens, 0..5
SEC_ONES  out  4  BCD seconds ones
END  out  1  time expired, registered
LOW  out  1  remaining time below 10 s and END=0, combinational from digit registers

Behaviour:
- Reset: CLR is asynchronous, active-high; clock is CLK. On CLR, digits = BCD(INIT_MIN):BCD(INIT_SEC), tick counter = 0, END = (preset == 00:00).
- Priority per cycle, highest first: CLR, LOAD, END freeze, MOVE_DONE, ENABLE.
- LOAD=1: same values as reset. ENABLE and MOVE_DONE are ignored that cycle.
- END=1: all state frozen, time held at 00:00. Only LOAD or CLR clears it.
- ENABLE=1, END=0, LOAD=0:
  - If tick < TICKS_PER_SEC-1, tick increments.
  - Otherwise tick <= 0 and time decrements by one second.
  - Registered, so outputs update the cycle after the strobe.
- BCD decrement:
  - SEC_ONES 0 → 9 with borrow to SEC_TENS.
  - SEC_TENS 0 → 5 with borrow to MIN_ONES.
  - MIN_ONES 0 → 9 with borrow to MIN_TENS.
  - A decrement that yields 00:00 sets END in the same register update (END and 00:00 appear on the same cycle).
- ENABLE=0: tick counter and time hold. The partial second is retained across turns, not cleared.
- MOVE_DONE=1, END=0, LOAD=0:
  - Add INC_SEC seconds in BCD with carries (seconds wrap at 60 into minutes).
  - Saturate at 99:59.
  - Tick counter unchanged.
  - If ENABLE=1 in the same cycle, the increment takes effect and ENABLE is ignored (the switch stage never asserts both on one instance).
- INC_SEC=0: MOVE_DONE has no effect.
- LOW = (MIN_TENS=0 && MIN_ONES=0 && SEC_TENS=0 && END=0).
- Out-of-range parameters are illegal. Implementation may assert at elaboration.
- No internal state other than the 4 digit registers, the tick counter (clog2(TICKS_PER_SEC) bits) and END.

Test Plan:
- Reset/LOAD: INIT 05:00, assert CLR mid-count at 04:37 → outputs 0,5,0,0, END=0, LOW=0. Then LOAD after further counting → 05:00, tick=0.
- Basic count: TICKS_PER_SEC=10, 10 ENABLE strobes from 05:00 → 04:59 one cycle after the 10th strobe; 9 strobes → still 05:00.
- Borrow chain: INIT 10:00, 10 strobes → 09:59. INIT 00:10 → at 00:09 LOW=1.
- Expiry: INIT 00:01, 10 strobes → 00:00 and END=1 on the same cycle. Further ENABLE/MOVE_DONE → no change. LOAD → 00:01, END=0.
- Increment: INC_SEC=5, time 01:57, MOVE_DONE → 02:02. Time 99:57 → 99:59 saturated. MOVE_DONE at END=1 → ignored.
- Partial second retention: 6 strobes, ENABLE low 100 cycles, then 4 strobes → decrements exactly once after the 4th.
